// File: rtl/rvb_clmul_issue_pkg.sv
// rvb_clmul_pkg: CLMUL-family decode constants, queue entry and decode helper.
// RVB_CLMUL_ISSUE_WOPS_EN makes the OP-32 W forms legal when XLEN is 64.
package rvb_clmul_pkg;
  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OP32  = 7'b0111011;
  localparam logic [6:0] F7_CLMUL  = 7'b0000101;
  localparam logic [2:0] F3_CLMUL  = 3'b001;
  localparam logic [2:0] F3_CLMULR = 3'b010;
  localparam logic [2:0] F3_CLMULH = 3'b011;
`ifdef RVB_CLMUL_ISSUE_WOPS_EN
  localparam bit WOPS_EN = 1'b1;
`else
  localparam bit WOPS_EN = 1'b0;
`endif
  typedef struct packed {
    logic [4:0] rd;
    logic       illegal;
  } q_entry_t;
  typedef struct packed {
    logic legal;
    logic w;
  } dec_t;
  function automatic dec_t decode(input logic [31:0] insn, input logic xlen64);
    logic f_ok;
    logic w;
    f_ok = insn[31:25] == F7_CLMUL && (insn[14:12] inside {F3_CLMUL, F3_CLMULR, F3_CLMULH});
    w = xlen64 && insn[6:0] == OPC_OP32;
    return '{legal: f_ok && (insn[6:0] == OPC_OP || (WOPS_EN && w)), w: w};
  endfunction
endpackage

// File: rtl/rvb_clmul_issue_if.sv
// rvb_clmul_issue_if: instruction, core din/dout and writeback handshakes of rvb_clmul_issue.
interface rvb_clmul_issue_if #(parameter int XLEN = 64);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_insn;
  logic [XLEN-1:0] in_rs1;
  logic [XLEN-1:0] in_rs2;
  logic            core_din_valid;
  logic            core_din_ready;
  logic [XLEN-1:0] core_din_rs1;
  logic [XLEN-1:0] core_din_rs2;
  logic            core_din_insn3;
  logic            core_din_insn12;
  logic            core_din_insn13;
  logic            core_dout_valid;
  logic            core_dout_ready;
  logic [XLEN-1:0] core_dout_rd;
  logic            wb_valid;
  logic            wb_ready;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_value;
  logic            wb_illegal;
  modport slave (
    input  in_valid, in_insn, in_rs1, in_rs2, core_din_ready, core_dout_valid, core_dout_rd, wb_ready,
    output in_ready, core_din_valid, core_din_rs1, core_din_rs2, core_din_insn3, core_din_insn12,
           core_din_insn13, core_dout_ready, wb_valid, wb_rd, wb_value, wb_illegal
  );
  modport master (
    output in_valid, in_insn, in_rs1, in_rs2, core_din_ready, core_dout_valid, core_dout_rd, wb_ready,
    input  in_ready, core_din_valid, core_din_rs1, core_din_rs2, core_din_insn3, core_din_insn12,
           core_din_insn13, core_dout_ready, wb_valid, wb_rd, wb_value, wb_illegal
  );
endinterface

// File: rtl/rvb_issue_fifo.sv
// rvb_issue_fifo: generic DEPTH-entry pointer FIFO with full/empty and simultaneous push/pop.
module rvb_issue_fifo #(
  parameter int WIDTH = 6,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    head_q, head_d, tail_q, tail_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;
  // Full blocks push even alongside a pop: no pass-through path.
  assign full_o  = count_q == (AW+1)'(DEPTH);
  assign empty_o = count_q == '0;
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[head_q];
  always_comb begin
    head_d  = do_pop ? head_q + AW'(1) : head_q;
    tail_d  = do_push ? tail_q + AW'(1) : tail_q;
    count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end
  always_ff @(posedge clock) begin
    if (do_push) mem_q[tail_q] <= wdata_i;
  end
endmodule

// File: rtl/rvb_clmul_issue.sv
// rvb_clmul_issue: decodes CLMUL-family insns, feeds the core and retires results in order.
// RVB_CLMUL_ISSUE_WOPS_EN (in rvb_clmul_pkg) enables the OP-32 W forms on XLEN 64.
module rvb_clmul_issue
  import rvb_clmul_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int DEPTH = 4
) (
  input logic              clock,
  input logic              resetn,
  rvb_clmul_issue_if.slave bus
);
  dec_t            dec;
  q_entry_t        head, push_entry;
  logic            full, empty, push, pop, load;
  logic            wb_valid_q, wb_valid_d, wb_illegal_q, wb_illegal_d;
  logic [4:0]      wb_rd_q, wb_rd_d;
  logic [XLEN-1:0] wb_value_q, wb_value_d;
  logic            unused_w;
  assign dec      = decode(bus.in_insn, XLEN == 64);
  assign unused_w = dec.w;
  assign bus.in_ready        = !full && (!dec.legal || bus.core_din_ready);
  assign bus.core_din_valid  = bus.in_valid && dec.legal && !full;
  assign bus.core_din_rs1    = bus.in_rs1;
  assign bus.core_din_rs2    = bus.in_rs2;
  assign bus.core_din_insn3  = bus.in_insn[3];
  assign bus.core_din_insn12 = bus.in_insn[12];
  assign bus.core_din_insn13 = bus.in_insn[13];
  assign push       = bus.in_valid && bus.in_ready;
  assign push_entry = '{rd: bus.in_insn[11:7], illegal: !dec.legal};
  // Illegal heads retire on their own; legal heads wait for the core result.
  assign load                = (!wb_valid_q || bus.wb_ready) && !empty;
  assign bus.core_dout_ready = load && !head.illegal;
  assign pop                 = load && (head.illegal || bus.core_dout_valid);
  rvb_issue_fifo #(.WIDTH($bits(q_entry_t)), .DEPTH(DEPTH)) u_fifo (
    .clock   (clock),
    .resetn  (resetn),
    .push_i  (push),
    .wdata_i (push_entry),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty)
  );
  always_comb begin
    wb_valid_d   = pop || (wb_valid_q && !bus.wb_ready);
    wb_rd_d      = pop ? head.rd : wb_rd_q;
    wb_value_d   = pop ? (head.illegal ? '0 : bus.core_dout_rd) : wb_value_q;
    wb_illegal_d = pop ? head.illegal : wb_illegal_q;
  end
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wb_valid_q   <= 1'b0;
      wb_rd_q      <= '0;
      wb_value_q   <= '0;
      wb_illegal_q <= 1'b0;
    end else begin
      wb_valid_q   <= wb_valid_d;
      wb_rd_q      <= wb_rd_d;
      wb_value_q   <= wb_value_d;
      wb_illegal_q <= wb_illegal_d;
    end
  end
  assign bus.wb_valid   = wb_valid_q;
  assign bus.wb_rd      = wb_rd_q;
  assign bus.wb_value   = wb_value_q;
  assign bus.wb_illegal = wb_illegal_q;
endmodule

// File: tb/tb_rvb_clmul_issue.sv
// tb_rvb_clmul_issue: scoreboard bench with a behavioural CLMUL core model and random traffic.
module tb_rvb_clmul_issue;
  localparam int XLEN  = 64;
  localparam int DEPTH = 4;
`ifdef RVB_CLMUL_ISSUE_WOPS_EN
  localparam bit WOPS = 1'b1;
`else
  localparam bit WOPS = 1'b0;
`endif
  typedef struct {
    logic [4:0]  rd;
    logic [63:0] value;
    logic        illegal;
  } exp_t;

  logic clock  = 1'b0;
  logic resetn = 1'b1;
  always #5 clock = ~clock;

  rvb_clmul_issue_if #(.XLEN(XLEN)) bus ();
  rvb_clmul_issue #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (.clock(clock), .resetn(resetn), .bus(bus));

  exp_t        exp_q[$];
  logic [63:0] core_res_q[$];
  int          core_lat_q[$];
  int          checks = 0, failures = 0;
  int          rdy_pct = 100, lat_min = 0, lat_max = 0, wb_mode = 1;

  function automatic bit ref_legal(input logic [31:0] insn);
    bit f_ok = insn[31:25] == 7'd5 && insn[14:12] >= 3'd1 && insn[14:12] <= 3'd3;
    return f_ok && (insn[6:0] == 7'h33 || (WOPS && insn[6:0] == 7'h3B));
  endfunction

  // Carry-less product by shift/xor, then low / high / reversed-window selection.
  function automatic logic [63:0] ref_clmul(input logic [2:0] f3, input bit w, input logic [63:0] a,
                                            input logic [63:0] b);
    logic [127:0] p = '0;
    logic [127:0] s;
    int n = w ? 32 : 64;
    if (w) begin
      a = {32'b0, a[31:0]};
      b = {32'b0, b[31:0]};
    end
    for (int i = 0; i < n; i++) if (b[i]) p ^= {64'b0, a} << i;
    s = f3 == 3'b001 ? p : f3 == 3'b011 ? p >> n : p >> (n - 1);
    if (w) s = {{96{s[31]}}, s[31:0]};
    return s[63:0];
  endfunction

  function automatic logic [31:0] mk(input logic [2:0] f3, input logic [4:0] rd, input bit w);
    return {7'b0000101, 5'd2, 5'd1, f3, rd, w ? 7'b0111011 : 7'b0110011};
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
    checks++;
    if (got !== req) begin
      failures++;
      $display("FAIL %s got=%h required=%h", name, got, req);
    end
  endtask

  task automatic issue(input logic [31:0] insn, input logic [63:0] rs1, input logic [63:0] rs2,
                       input bit force_exp = 1'b0, input logic [63:0] fexp = '0);
    exp_t e;
    bit legal = ref_legal(insn);
    e.rd      = insn[11:7];
    e.illegal = !legal;
    e.value   = !legal ? 64'd0 : force_exp ? fexp : ref_clmul(insn[14:12], insn[6:0] == 7'h3B, rs1, rs2);
    bus.in_valid = 1'b1;
    bus.in_insn  = insn;
    bus.in_rs1   = rs1;
    bus.in_rs2   = rs2;
    for (int i = 0; i < 500; i++) begin
      @(negedge clock);
      if (bus.in_ready) begin
        exp_q.push_back(e);
        @(posedge clock);
        #1 bus.in_valid = 1'b0;
        return;
      end
      @(posedge clock);
      #1;
    end
    checks++;
    failures++;
    $display("FAIL issue_timeout insn=%h never accepted", insn);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 3000 && exp_q.size() > 0; i++) @(posedge clock);
    #1 check("drain_left", 64'(exp_q.size()), 64'd0);
  endtask

  // Behavioural core: accepts on din handshake, answers after a random latency.
  initial begin
    bus.core_din_ready  = 1'b0;
    bus.core_dout_valid = 1'b0;
    bus.core_dout_rd    = '0;
    forever begin
      bit take_in, take_out;
      logic [63:0] r;
      @(negedge clock);
      take_in  = resetn && bus.core_din_valid && bus.core_din_ready;
      take_out = resetn && bus.core_dout_valid && bus.core_dout_ready;
      r = ref_clmul({1'b0, bus.core_din_insn13, bus.core_din_insn12}, bus.core_din_insn3,
                    bus.core_din_rs1, bus.core_din_rs2);
      @(posedge clock);
      #1;
      if (!resetn) begin
        core_res_q.delete();
        core_lat_q.delete();
      end else begin
        if (take_out) begin
          void'(core_res_q.pop_front());
          void'(core_lat_q.pop_front());
        end
        if (take_in) begin
          core_res_q.push_back(r);
          core_lat_q.push_back($urandom_range(lat_min, lat_max));
        end
        if (core_lat_q.size() > 0 && core_lat_q[0] > 0) core_lat_q[0]--;
      end
      bus.core_dout_valid = resetn && core_res_q.size() > 0 && core_lat_q[0] == 0;
      bus.core_dout_rd    = bus.core_dout_valid ? core_res_q[0] : {$urandom, $urandom};
      bus.core_din_ready  = $urandom_range(1, 100) <= rdy_pct;
    end
  end

  initial begin
    bus.wb_ready = 1'b1;
    forever begin
      @(posedge clock);
      #1 bus.wb_ready = wb_mode == 2 ? 1'($urandom_range(0, 1)) : wb_mode == 1;
    end
  end

  // Writeback monitor: every accepted result must match the oldest expectation.
  always @(negedge clock) begin
    exp_t e;
    if (resetn && bus.wb_valid && bus.wb_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL wb_unexpected got rd=%0d value=%h illegal=%0b required=none",
                 bus.wb_rd, bus.wb_value, bus.wb_illegal);
      end else begin
        e = exp_q.pop_front();
        checks++;
        if (bus.wb_rd !== e.rd || bus.wb_value !== e.value || bus.wb_illegal !== e.illegal) begin
          failures++;
          $display("FAIL wb_result got rd=%0d value=%h illegal=%0b required rd=%0d value=%h illegal=%0b",
                   bus.wb_rd, bus.wb_value, bus.wb_illegal, e.rd, e.value, e.illegal);
        end
      end
    end
  end

  always @(negedge clock) begin
    if (resetn && bus.in_valid) begin
      if (!ref_legal(bus.in_insn)) check("din_valid_illegal", 64'(bus.core_din_valid), 64'd0);
      else if (bus.core_din_ready) check("din_valid_vs_in_ready", 64'(bus.core_din_valid), 64'(bus.in_ready));
      else check("in_ready_core_busy", 64'(bus.in_ready), 64'd0);
      if (bus.core_din_valid) check("din_rs1", bus.core_din_rs1, bus.in_rs1);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.in_insn  = '0;
    bus.in_rs1   = '0;
    bus.in_rs2   = '0;
    #2 resetn = 1'b0;
    repeat (3) @(posedge clock);
    #1 resetn = 1'b1;
    @(posedge clock);
    #1;
    check("reset_wb_valid", 64'(bus.wb_valid), 64'd0);
    check("reset_wb_rd", 64'(bus.wb_rd), 64'd0);
    check("reset_wb_value", bus.wb_value, 64'd0);
    check("reset_wb_illegal", 64'(bus.wb_illegal), 64'd0);
    check("reset_in_ready", 64'(bus.in_ready), 64'd1);
    check("reset_din_valid", 64'(bus.core_din_valid), 64'd0);

    issue(32'h0A2091B3, 64'd3, 64'd5, 1'b1, 64'hF);
    issue(mk(3'b011, 5'd4, 1'b0), 64'h8000_0000_0000_0000, 64'd2, 1'b1, 64'd1);
    issue(mk(3'b010, 5'd5, 1'b0), 64'h8000_0000_0000_0000, 64'd2, 1'b1, 64'd2);
    drain();

    issue(32'h0000_0013, 64'd0, 64'd0);
    check("illegal_not_early", 64'(bus.wb_valid), 64'd0);
    @(posedge clock);
    #1;
    check("illegal_lat_valid", 64'(bus.wb_valid), 64'd1);
    check("illegal_lat_flag", 64'(bus.wb_illegal), 64'd1);
    check("illegal_lat_value", bus.wb_value, 64'd0);
    drain();

    lat_min = 6;
    lat_max = 6;
    issue(mk(3'b001, 5'd9, 1'b0), 64'd3, 64'd5, 1'b1, 64'hF);
    issue(32'h0000_0393, 64'd0, 64'd0);
    drain();
    lat_min = 0;
    lat_max = 0;

    wb_mode = 0;
    repeat (2) @(posedge clock);
    #1;
    for (int k = 1; k <= DEPTH + 1; k++) issue(32'h13 | (32'(k) << 7), 64'd0, 64'd0);
    bus.in_valid = 1'b1;
    bus.in_insn  = 32'h13 | (32'(DEPTH + 2) << 7);
    repeat (3) begin
      @(negedge clock);
      check("full_in_ready", 64'(bus.in_ready), 64'd0);
      check("full_hold_rd", 64'(bus.wb_rd), 64'd1);
      @(posedge clock);
      #1;
    end
    wb_mode = 1;
    issue(32'h13 | (32'(DEPTH + 2) << 7), 64'd0, 64'd0);
    drain();

    wb_mode = 0;
    repeat (2) @(posedge clock);
    #1;
    issue(32'h0000_0B13, 64'd0, 64'd0);
    lat_min = 20;
    lat_max = 20;
    issue(mk(3'b001, 5'd11, 1'b0), 64'd3, 64'd5);
    issue(mk(3'b011, 5'd12, 1'b0), 64'd7, 64'd9);
    @(posedge clock);
    #1 check("rst_pre_wb_valid", 64'(bus.wb_valid), 64'd1);
    #2 resetn = 1'b0;
    #1;
    check("rst_wb_valid", 64'(bus.wb_valid), 64'd0);
    check("rst_wb_rd", 64'(bus.wb_rd), 64'd0);
    check("rst_wb_illegal", 64'(bus.wb_illegal), 64'd0);
    exp_q.delete();
    bus.in_insn = '0;
    repeat (2) @(posedge clock);
    #1 resetn = 1'b1;
    wb_mode = 1;
    lat_min = 0;
    lat_max = 3;
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    repeat (40) @(posedge clock);
    #1 check("rst_no_stale", 64'(bus.wb_valid), 64'd0);

    issue(mk(3'b001, 5'd10, 1'b1), 64'hAAAA_AAAA_8000_0000, 64'd1, 1'b1, 64'hFFFF_FFFF_8000_0000);
    issue(mk(3'b011, 5'd13, 1'b1), 64'h1234_5678_F000_000F, 64'h0000_0000_8000_0001);
    drain();

    wb_mode = 2;
    rdy_pct = 70;
    for (int n = 0; n < 300; n++) begin
      logic [31:0] insn;
      logic [4:0]  rd = 5'($urandom);
      case ($urandom_range(0, 5))
        0, 1, 2: insn = mk(3'($urandom_range(1, 3)), rd, 1'b0);
        3:       insn = mk(3'($urandom_range(1, 3)), rd, 1'b1);
        4:       insn = mk(3'($urandom_range(0, 7)), rd, 1'b0);
        default: insn = $urandom;
      endcase
      issue(insn, {$urandom, $urandom}, {$urandom, $urandom});
      if ($urandom_range(0, 7) == 0) repeat ($urandom_range(1, 4)) @(posedge clock);
      #0;
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/rvb_clmul_issue.md
Name: rvb_clmul_issue

Overview:
Issue/retire wrapper directly upstream and downstream of the carry-less multiply core (rvb_clmul). Decodes a raw 32-bit instruction plus operands and drives the core's din_* handshake. Answers non-CLMUL encodings itself without involving the core. Keeps an in-order outstanding-op queue so results leave through one registered writeback port, tagged with rd, in program order.

Parameters:
XLEN, 64, datapath width; 32 or 64 only.
DEPTH, 4, outstanding-op queue entries; power of 2, at least 2.

Ports:
clock  input  1  positive-edge clock
resetn  input  1  asynchronous active-low reset
in_valid  input  1  instruction offered
in_ready  output  1  instruction accepted this cycle
in_insn  input  32  raw instruction word
in_rs1  input  XLEN  1st operand value
in_rs2  input  XLEN  2nd operand value
core_din_valid  output  1  to core din_valid
core_din_ready  input  1  from core din_ready
core_din_rs1  output  XLEN  to core din_rs1
core_din_rs2  output  XLEN  to core din_rs2
core_din_insn3  output  1  in_insn[3]
core_din_insn12  output  1  in_insn[12]
core_din_insn13  output  1  in_insn[13]
core_dout_valid  input  1  from core dout_valid
core_dout_ready  output  1  to core dout_ready
core_dout_rd  input  XLEN  core result
wb_valid  output  1  writeback valid (registered)
wb_ready  input  1  writeback accepted
wb_rd  output  5  destination register index
wb_value  output  XLEN  result; 0 when wb_illegal
wb_illegal  output  1  instruction was not a legal CLMUL-family op

Behaviour:
- Legal decode: funct7 = in_insn[31:25] == 7'b0000101, funct3 = in_insn[14:12] in {001, 010, 011}, and opcode = in_insn[6:0] == 7'b0110011. The W forms use opcode 7'b0111011 and are legal only when the optional feature is enabled and XLEN == 64. Every other encoding is illegal.
- Queue entry: {rd = in_insn[11:7], illegal}. Head and tail pointers are log2(DEPTH) bits and wrap modulo DEPTH. A separate count of width log2(DEPTH)+1 gives full and empty.
- in_ready = !full && (illegal || core_din_ready). It is combinational; core_din_ready does not depend on in_valid.
- core_din_valid = in_valid && legal && !full. The core_din_* data fields are wired straight from the inputs.
- Push: in_valid && in_ready. Full blocks push even when a pop happens in the same cycle; there is no pass-through.
- Output register: it loads when (!wb_valid || wb_ready) and the queue is not empty.
  - Head illegal: load {rd, value 0, illegal 1} and pop. The core is not touched.
  - Head legal: core_dout_ready = 1. When core_dout_valid is also high, load {rd, core_dout_rd, 0} and pop.
  - core_dout_ready is 0 in every other case.
- Latency: an illegal op at an empty queue is wb_valid 1 cycle after acceptance. A legal op is wb_valid 1 cycle after the core's dout handshake.
- Ordering: strictly in-order. An illegal op queued behind a legal op waits for that op's result.
- Simultaneous push and pop: both take effect, so count is unchanged.
- Reset (asynchronous, any time, including mid-operation):
  - pointers and count cleared to 0; wb_valid 0; wb_rd, wb_value and wb_illegal 0.
  - in-flight ops are discarded.
  - The integrating level must drive the core's synchronous reset with !resetn so both sides flush together.
- Unknown data from the core when core_dout_valid is low is never loaded.

Optional Feature:
RVB_CLMUL_ISSUE_WOPS_EN
- Defined: OP-32 CLMULW, CLMULRW and CLMULHW are legal when XLEN == 64 and are forwarded with insn3 = 1.
- Undefined: those encodings decode as illegal and are answered with wb_illegal = 1. Nothing with insn3 = 1 ever reaches the core.

Decomposition:
- Package rvb_clmul_pkg holds:
  - the opcode, funct7 and funct3 localparams;
  - the queue-entry typedef {rd[4:0], illegal};
  - the decode function returning {legal, w}.
- Natural sub-module: rvb_issue_fifo, a generic DEPTH-entry pointer FIFO with full/empty flags and simultaneous push/pop. It is reusable by other rvb_* units.

Test Plan:
- CLMUL, insn 0x0A2091B3 (rd = 3), rs1 = 3, rs2 = 5 -> wb_valid, wb_rd = 3, wb_value = 0xF, wb_illegal = 0.
- CLMULH, XLEN = 64, rs1 = 0x8000_0000_0000_0000, rs2 = 2 -> wb_value = 1. The same operands with CLMULR (funct3 = 010) -> wb_value = 2.
- Illegal insn 0x00000013 (ADDI) -> core_din_valid stays 0, next cycle wb_illegal = 1 with wb_value = 0. Issued behind a pending CLMUL, it must retire after that CLMUL.
- Hold wb_ready = 0 and issue DEPTH + 1 illegal ops -> in_ready = 0 once DEPTH entries are queued. Release wb_ready -> ops retire in order with rd 1..5 and the pointers wrap correctly.
- Deassert resetn while the core is busy and the queue holds 2 entries -> wb_valid = 0 immediately, in_ready = 1 after release, and no stale result is ever written back.
- CLMULW, opcode 0111011 -> with the macro, the core receives insn3 = 1 and wb_value is sign-extended from bit 31. Without the macro, wb_illegal = 1.
